// File: rtl/div.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// A zero divisor skips the iteration phase and reports all-ones / raw dividend.
module div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       ctrl,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             zero_div;

  logic             is_uns;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic             last_iter;
  logic             unused_bits;

  assign is_uns    = (ctrl[1:0] == 2'b11);
  assign a_mag     = (!is_uns && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (!is_uns && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Trial subtraction carries an extra bit so divisors >= 2^(WIDTH-1) still compare correctly.
  assign rem_sh    = {prem, dvd[WIDTH-1]};
  assign trial     = {1'b0, rem_sh} - {2'b00, dvs};
  assign q_bit     = ~trial[WIDTH+1];
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign unused_bits = ^{ctrl[4:2], trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (b == '0) ? FIX : RUN;
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            prem     <= '0;
            dvs      <= b_mag;
            q_neg    <= !is_uns && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg    <= !is_uns && a[WIDTH-1];
            zero_div <= (b == '0);
            // Zero divisor keeps the raw dividend so it can be returned unmodified.
            if (b == '0) begin
              dvd <= a;
            end else begin
              dvd         <= a_mag;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          prem <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= q_neg ? (~dvd + 1'b1) : dvd;
            remainder <= r_neg ? (~prem + 1'b1) : prem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only when idle.
REQ-005 SHALL have port a, input, WIDTH, the dividend.
REQ-006 SHALL have port b, input, WIDTH, the divisor.
REQ-007 SHALL have port ctrl, input, 5, the operation select; only ctrl[1:0] is used (2'b11 unsigned, any other value signed); ctrl[4:2] is ignored.
REQ-008 SHALL have port quotient, output, WIDTH, the registered quotient.
REQ-009 SHALL have port remainder, output, WIDTH, the registered remainder.
REQ-010 SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse marking new quotient/remainder values.
REQ-012 SHALL have port div_by_zero, output, 1, registered flag for the result currently on quotient/remainder.

Function
REQ-013 SHALL implement states IDLE, RUN and FIX.
REQ-014 SHALL, when start=1 in IDLE at edge E0, capture |a| and |b| (or raw a and b if unsigned), capture the result signs and ctrl[1:0], clear the partial remainder and the iteration counter, and go to RUN.
REQ-015 SHALL compute the result signs as: quotient negative = a[MSB] XOR b[MSB]; remainder negative = a[MSB]; both signs apply only in signed mode.
REQ-016 SHALL, in RUN, perform one restoring iteration per edge: shift {partial remainder, dividend} left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and shift in quotient bit 1 if so (else 0).
REQ-017 SHALL use a trial subtraction one bit wider than WIDTH, so that unsigned divisors of 2^(WIDTH-1) and above are handled.
REQ-018 SHALL spend exactly WIDTH edges in RUN (E1..E32 at WIDTH=32), then go to FIX.
REQ-019 SHALL, at FIX edge E33, two's-complement negate the magnitudes per the result signs, register quotient/remainder, set done=1 for exactly one cycle, and return to IDLE.
REQ-020 SHALL give a latency of WIDTH+1 edges from the start edge to the done cycle.
REQ-021 SHALL drive busy=1 exactly while in RUN or FIX; busy and done SHALL never both be high.
REQ-022 SHALL ignore start whenever busy=1, with no effect on the operation in flight.
REQ-023 SHALL allow start in the same cycle as done=1 (state is IDLE), and accept it.
REQ-024 SHALL, if b==0 at the start edge: skip RUN, go directly to FIX, and at E1 output quotient=all ones, remainder=a (unmodified), div_by_zero=1, done=1.
REQ-025 SHALL clear div_by_zero at each accepted start whose b is nonzero.
REQ-026 SHALL, for signed overflow (a=most-negative, b=-1), produce quotient=most-negative value and remainder=0 with no special path.
REQ-027 SHALL truncate the quotient toward zero and give the remainder the dividend's sign (a = q*b + r).
REQ-028 SHALL hold quotient, remainder and div_by_zero stable between done pulses.
REQ-029 SHALL ignore changes on a, b or ctrl after the start edge.

Reset
REQ-030 SHALL, with rst_n=0 at an edge, force state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and counter=0, regardless of start or the current state.
REQ-031 SHALL, if reset occurs mid-operation, abandon the operation without a done pulse; a start in the first edge after rst_n rises SHALL be accepted normally.

Verification
REQ-032 SHALL cover: a=100, b=7, ctrl=5'b00011 -> quotient=14, remainder=2, done exactly 33 edges after the start edge, busy high for 33 cycles.
REQ-033 SHALL cover: a=0xFFFFFFF9 (-7), b=2, ctrl=0 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; and a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
REQ-034 SHALL cover: a=0x80000000, b=0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0; same operands unsigned -> quotient=0, remainder=0x80000000.
REQ-035 SHALL cover: a=5, b=0, either mode -> done one edge after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-036 SHALL cover: start re-pulsed with different operands at cycle 10 of a busy operation -> ignored, original result returned; back-to-back start on the done cycle -> accepted.
REQ-037 SHALL cover: rst_n=0 at cycle 15 of an operation -> no done pulse, all outputs 0 next cycle; a new start after reset completes correctly.
